// File: rtl/brownout_ctrl_if.sv
// Comparator-side signal bundle for brownout_ctrl; master = power-management/comparator side, slave = controller.
// With BROWNOUT_STICKY_EN defined the bundle also carries stky_clr / brout_stky.
interface brownout_ctrl_if;
  logic en;
  logic cmp_out;
  logic ibias_ena;
  logic cmp_ena;
  logic cmp_rdy;
  logic brout;
  logic brout_raw;
`ifdef BROWNOUT_STICKY_EN
  logic stky_clr;
  logic brout_stky;

  modport master (
    output en, cmp_out, stky_clr,
    input  ibias_ena, cmp_ena, cmp_rdy, brout, brout_raw, brout_stky
  );
  modport slave (
    input  en, cmp_out, stky_clr,
    output ibias_ena, cmp_ena, cmp_rdy, brout, brout_raw, brout_stky
  );
`else
  modport master (
    output en, cmp_out,
    input  ibias_ena, cmp_ena, cmp_rdy, brout, brout_raw
  );
  modport slave (
    input  en, cmp_out,
    output ibias_ena, cmp_ena, cmp_rdy, brout, brout_raw
  );
`endif
endinterface

// File: rtl/brownout_ctrl.sv
// Brownout comparator controller: power-up sequencing, 2-flop sync, asymmetric debounce; assert after 1+ASSERT_CNT edges.
// Optional sticky brownout latch (brout_stky, cleared by stky_clr) when BROWNOUT_STICKY_EN is defined.
module brownout_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int ASSERT_CNT    = 4,
  parameter int DEASSERT_CNT  = 64,
  parameter int CNT_W         = 8
) (
  input logic            clk,
  input logic            rst_n,
  brownout_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ASSERT_LAST   = CNT_W'(ASSERT_CNT - 1);
  localparam logic [CNT_W-1:0] DEASSERT_LAST = CNT_W'(DEASSERT_CNT - 1);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    BIAS    = 3'd1,
    SETTLE  = 3'd2,
    MONITOR = 3'd3,
    TRIPPED = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sync1, sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.cmp_out;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= OFF;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Disable overrides everything, including a trip that would land on the same edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!bus.en) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        OFF: begin
          state_nxt = BIAS;
          cnt_nxt   = '0;
        end
        BIAS: begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state_nxt = MONITOR;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        MONITOR: begin
          if (!sync2) begin
            cnt_nxt = '0;
          end else if (cnt == ASSERT_LAST) begin
            state_nxt = TRIPPED;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        TRIPPED: begin
          if (sync2) begin
            cnt_nxt = '0;
          end else if (cnt == DEASSERT_LAST) begin
            state_nxt = MONITOR;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = OFF;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  logic ibias_ena, cmp_ena, cmp_rdy, brout;

  always_comb begin
    ibias_ena = 1'b0;
    cmp_ena   = 1'b0;
    cmp_rdy   = 1'b0;
    brout     = 1'b0;
    case (state)
      BIAS: begin
        ibias_ena = 1'b1;
      end
      SETTLE: begin
        ibias_ena = 1'b1;
        cmp_ena   = 1'b1;
      end
      MONITOR: begin
        ibias_ena = 1'b1;
        cmp_ena   = 1'b1;
        cmp_rdy   = 1'b1;
      end
      TRIPPED: begin
        ibias_ena = 1'b1;
        cmp_ena   = 1'b1;
        cmp_rdy   = 1'b1;
        brout     = 1'b1;
      end
      default: begin
        ibias_ena = 1'b0;
      end
    endcase
  end

  assign bus.ibias_ena = ibias_ena;
  assign bus.cmp_ena   = cmp_ena;
  assign bus.cmp_rdy   = cmp_rdy;
  assign bus.brout     = brout;
  assign bus.brout_raw = sync2;

`ifdef BROWNOUT_STICKY_EN
  logic stky;
  logic brout_rise;

  // A rise on the coming edge beats a simultaneous clear request.
  assign brout_rise = (state_nxt == TRIPPED) && (state != TRIPPED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stky <= 1'b0;
    end else if (brout_rise) begin
      stky <= 1'b1;
    end else if (bus.stky_clr) begin
      stky <= 1'b0;
    end
  end

  assign bus.brout_stky = stky;
`endif

endmodule

// File: tb/tb_brownout_ctrl.sv
// Directed bench for brownout_ctrl: stimulus schedules expected outputs per clock edge, a monitor checks them.
module tb_brownout_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   edges = 0;
  bit   done = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  brownout_ctrl_if bus ();

  brownout_ctrl #(
    .SETTLE_CYCLES(16),
    .ASSERT_CNT   (4),
    .DEASSERT_CNT (64),
    .CNT_W        (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  // kind 0: {ibias_ena, cmp_ena, cmp_rdy, brout, brout_raw}; kind 1: {4'b0, brout_stky}
  typedef struct {
    int         at;
    bit         kind;
    string      nm;
    logic [4:0] v;
  } exp_t;

  exp_t exp_q[$];

  logic [4:0] got_main;
  logic [4:0] got_stky;
  assign got_main = {bus.ibias_ena, bus.cmp_ena, bus.cmp_rdy, bus.brout, bus.brout_raw};
`ifdef BROWNOUT_STICKY_EN
  assign got_stky = {4'b0000, bus.brout_stky};
`else
  assign got_stky = 5'b00000;
`endif

  task automatic expv(input int at, input string nm, input logic [4:0] v);
    exp_t e;
    e.at = at; e.kind = 1'b0; e.nm = nm; e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic exps(input int at, input string nm, input logic b);
    exp_t e;
    e.at = at; e.kind = 1'b1; e.nm = nm; e.v = {4'b0000, b};
    exp_q.push_back(e);
  endtask

  // Return just after edge number e has taken effect.
  task automatic go(input int e);
    while (edges < e) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.en      = 1'b1;
    bus.cmp_out = 1'b1;
`ifdef BROWNOUT_STICKY_EN
    bus.stky_clr = 1'b0;
`endif
    expv(1, "rst_e1", 5'b00000);
    expv(2, "rst_e2", 5'b00000);
    expv(3, "rst_e3", 5'b00000);
`ifdef BROWNOUT_STICKY_EN
    exps(3, "rst_stky", 1'b0);
`endif
    go(3);
    rst_n       = 1'b1;
    bus.cmp_out = 1'b0;
    expv(4, "bias", 5'b10000);
    expv(5, "settle", 5'b11000);

    go(4);
    vectors++;
    if (bus.ibias_ena !== 1'b1) begin
      miscompares++;
      $display("FAIL direct_bias edge %0d: got %b expected 1", edges, bus.ibias_ena);
    end
    go(5);
    vectors++;
    if (bus.cmp_ena !== 1'b1) begin
      miscompares++;
      $display("FAIL direct_settle edge %0d: got %b expected 1", edges, bus.cmp_ena);
    end

    // Comparator activity while settling must not reach the debouncer.
    go(6);
    bus.cmp_out = 1'b1;
    expv(8, "settle_raw", 5'b11001);
    go(14);
    bus.cmp_out = 1'b0;
    expv(20, "settle_end", 5'b11000);
    expv(21, "rdy", 5'b11100);

    // Five 3-sample glitches.
    for (int r = 0; r < 5; r++) begin
      go(22 + 5 * r);
      bus.cmp_out = 1'b1;
      expv(24 + 5 * r, "glitch_hi", 5'b11101);
      expv(27 + 5 * r, "glitch_lo", 5'b11100);
      go(25 + 5 * r);
      bus.cmp_out = 1'b0;
    end
    expv(50, "glitch_end", 5'b11100);

    // Trip: cmp_out sampled high at edge 53, brout after edge 58.
    go(52);
    bus.cmp_out = 1'b1;
    expv(53, "trip_raw0", 5'b11100);
    expv(54, "trip_raw1", 5'b11101);
    expv(57, "trip_pre", 5'b11101);
    expv(58, "trip", 5'b11111);
`ifdef BROWNOUT_STICKY_EN
    exps(57, "stky_pre", 1'b0);
    exps(58, "stky_set", 1'b1);
`endif

    go(58);
    vectors++;
    if (bus.brout !== 1'b1) begin
      miscompares++;
      $display("FAIL direct_trip edge %0d: got %b expected 1", edges, bus.brout);
    end

    // Release: 63 low samples, one high, then 64 low.
    go(60);
    bus.cmp_out = 1'b0;
    expv(124, "rel_lo63", 5'b11110);
    go(123);
    bus.cmp_out = 1'b1;
    expv(125, "rel_hi", 5'b11111);
    go(124);
    bus.cmp_out = 1'b0;
    expv(189, "rel_pre", 5'b11110);
    expv(190, "release", 5'b11100);
    go(190);
    vectors++;
    if (bus.brout !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_release edge %0d: got %b expected 0", edges, bus.brout);
    end
    vectors++;
    if (bus.cmp_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL direct_release_rdy edge %0d: got %b expected 1", edges, bus.cmp_rdy);
    end
`ifdef BROWNOUT_STICKY_EN
    exps(190, "stky_hold", 1'b1);
    go(191);
    bus.stky_clr = 1'b1;
    go(192);
    bus.stky_clr = 1'b0;
    exps(192, "stky_clr", 1'b0);
`endif

    // Second trip at edge 198.
    go(192);
    bus.cmp_out = 1'b1;
    expv(197, "trip2_pre", 5'b11101);
    expv(198, "trip2", 5'b11111);
`ifdef BROWNOUT_STICKY_EN
    go(197);
    bus.stky_clr = 1'b1;
    exps(198, "stky_set_wins", 1'b1);
    go(198);
    bus.stky_clr = 1'b0;
`endif

    // Disable while tripped.
    go(200);
    bus.en = 1'b0;
    expv(200, "tripped", 5'b11111);
    expv(201, "dis_tripped", 5'b00001);
`ifdef BROWNOUT_STICKY_EN
    exps(201, "stky_en_off", 1'b1);
`endif
    go(201);
    bus.cmp_out = 1'b0;
    expv(203, "off_raw0", 5'b00000);

    // Re-enable, then disable during settle, then a full restart.
    go(203);
    bus.en = 1'b1;
    expv(204, "bias2", 5'b10000);
    expv(205, "settle2", 5'b11000);
    go(209);
    bus.en = 1'b0;
    expv(210, "dis_settle", 5'b00000);
    expv(212, "off_hold", 5'b00000);
    go(212);
    bus.en = 1'b1;
    expv(213, "bias3", 5'b10000);
    expv(214, "settle3", 5'b11000);
    expv(229, "settle3_end", 5'b11000);
    expv(230, "rdy3", 5'b11100);
`ifdef BROWNOUT_STICKY_EN
    go(225);
    bus.stky_clr = 1'b1;
    go(226);
    bus.stky_clr = 1'b0;
    exps(226, "stky_clr2", 1'b0);
`endif

    // Disable lands on the same edge as a trip: disable wins.
    go(232);
    bus.cmp_out = 1'b1;
    expv(237, "prio_pre", 5'b11101);
    expv(238, "prio", 5'b00001);
`ifdef BROWNOUT_STICKY_EN
    exps(238, "prio_stky", 1'b0);
`endif
    go(237);
    bus.en = 1'b0;

    go(240);
    done = 1'b1;
  end

  initial begin
    logic [4:0] got;
    while (!done) begin
      @(negedge clk);
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].at <= edges) begin
          got = exp_q[i].kind ? got_stky : got_main;
          vectors++;
          if (exp_q[i].at != edges || got !== exp_q[i].v) begin
            miscompares++;
            $display("FAIL %s edge %0d (due %0d): got %b expected %b",
                     exp_q[i].nm, edges, exp_q[i].at, got, exp_q[i].v);
          end
          exp_q.delete(i);
        end
      end
    end
    while (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s never checked (due edge %0d): got none expected %b",
               exp_q[0].nm, exp_q[0].at, exp_q[0].v);
      exp_q.delete(0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion by edge 240");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/brownout_ctrl.md
Name: brownout_ctrl

Overview:
- Digital controller on the receiving end of the brownout comparator's output.
- Powers the comparator up (bias enable, then comparator enable) and waits a settling interval.
- Synchronises the asynchronous comparator decision into the clock domain and debounces it with asymmetric assert/deassert counts.
- Drives a clean brownout flag to the reset/power-management logic.

Parameters:
- SETTLE_CYCLES, 16, cycles after cmp_ena rises during which cmp_out is ignored (>=1).
- ASSERT_CNT, 4, consecutive synced-high samples required to assert brout (>=1).
- DEASSERT_CNT, 64, consecutive synced-low samples required to deassert brout (>=1).
- CNT_W, 8, width of the shared settle/debounce counter; must hold max(SETTLE_CYCLES, ASSERT_CNT, DEASSERT_CNT).

Ports:
- clk  input  1  block clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- en  input  1  block enable from the power-management register
- cmp_out  input  1  comparator decision, asynchronous; 1 = supply below threshold
- ibias_ena  output  1  enables comparator bias current
- cmp_ena  output  1  enables comparator
- cmp_rdy  output  1  comparator settled and being monitored
- brout  output  1  debounced brownout flag
- brout_raw  output  1  synchronised, unfiltered comparator value (sync stage 2)

Behaviour:
- Reset: the only reset is rst_n (synchronous, active-low). While rst_n=0 at a rising edge:
  - state=OFF; counter=0; both sync flops=0.
  - all outputs 0: ibias_ena, cmp_ena, cmp_rdy, brout, brout_raw.
- All outputs are registered (decoded from registered state/flops); no combinational path from inputs to outputs.
- Synchroniser: two-flop chain on cmp_out, always clocking; s2 drives brout_raw and is the only sample used by the FSM.
- State OFF:
  - Outputs: ibias_ena=0, cmp_ena=0, cmp_rdy=0, brout=0.
  - en=1 -> BIAS.
- State BIAS:
  - ibias_ena=1 for exactly one cycle.
  - Next: SETTLE, counter cleared.
- State SETTLE:
  - Outputs: ibias_ena=1, cmp_ena=1; s2 ignored.
  - Counter increments each cycle.
  - When counter==SETTLE_CYCLES-1 -> MONITOR, counter cleared, cmp_rdy=1 from MONITOR entry.
- State MONITOR (brout=0):
  - s2=1: counter++; if counter==ASSERT_CNT-1 on that edge -> TRIPPED, brout=1, counter cleared.
  - s2=0: counter cleared.
- State TRIPPED (brout=1):
  - s2=0: counter++; if counter==DEASSERT_CNT-1 -> MONITOR, brout=0, counter cleared.
  - s2=1: counter cleared.
- Latency:
  - cmp_out stable high from before edge N while in MONITOR -> brout=1 after edge N+1+ASSERT_CNT.
  - Deassert is symmetric using DEASSERT_CNT.
- en=0 in any state: next edge -> OFF; all outputs except brout_raw forced 0; counter cleared. Takes priority over all other transitions, including a same-cycle trip.
- en re-asserted: full BIAS/SETTLE sequence is repeated; no shortcut.
- Counter never wraps; each compare is an equality to a parameter minus 1, with clear on transition.
- Glitch shorter than ASSERT_CNT samples: no effect on brout.

Optional Feature:
- Macro BROWNOUT_STICKY_EN.
- When defined:
  - Adds input stky_clr (1) and output brout_stky (1).
  - brout_stky sets on any cycle brout rises and stays set until stky_clr=1 at an edge.
  - Set wins over clear in the same cycle.
  - Reset value 0; unaffected by en.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset/power-up: rst_n=0 for 3 cycles then 1, en=1 -> ibias_ena=1 at edge 1, cmp_ena=1 at edge 2, cmp_rdy=1 after 16 settle cycles; all outputs 0 during reset.
- Trip: in MONITOR, cmp_out=1 held -> brout=1 exactly 2+4 edges later; brout_raw follows cmp_out with 2-edge delay.
- Glitch reject: cmp_out high for 3 cycles, then low, repeated 5 times -> brout stays 0; brout_raw toggles.
- Release: in TRIPPED, cmp_out low 63 cycles then high 1 cycle then low 64 -> brout deasserts only after the final 64th low sample.
- Disable mid-operation: en=0 during SETTLE and during TRIPPED -> next edge all outputs 0; re-enable restarts with a 16-cycle settle.
- Sticky (BROWNOUT_STICKY_EN): trip then release -> brout_stky remains 1; stky_clr pulse -> 0; stky_clr coincident with brout rise -> brout_stky=1.
